spi_slave: RTL

SPI responder (Mode 0, CPOL=0/CPHA=0, LSB-first, 8-bit frames) that sits at the far end of the team's Wishbone-SPI master link. It lets a second FPGA or test fixture talk to the master over the same wire protocol: it samples MOSI and drives MISO in the `clk` domain, moves receive bytes out as single-cycle strobes, and takes transmit bytes through a one-entry valid/ready buffer. Its bit order and shift direction mirror the master's shifter: serial out = bit 0, new bit enters at bit 7.

---
 rtl/spi_slave_pkg.sv | 14 +
 rtl/spi_slave_if.sv | 28 ++
 rtl/spi_slave_sync.sv | 38 +++
 rtl/spi_slave.sv | 111 +++++++++++
 4 files changed

// File: rtl/spi_slave_pkg.sv
// Shared constants and types for the SPI responder and its master-side peer.
package spi_slave_pkg;

   localparam int unsigned SPI_BITS  = 8;
   localparam int unsigned SPI_CNT_W = 3;

   localparam logic [SPI_BITS-1:0] DUMMY_DEFAULT = 8'hFF;

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } state_e;

endpackage

// File: rtl/spi_slave_if.sv
// SPI pins plus the byte-side TX/RX handshake of the SPI responder.
interface spi_slave_if;
   import spi_slave_pkg::*;

   logic                sclk;
   logic                cs_n;
   logic                mosi;
   logic                miso;
   logic                miso_oe;
   logic [SPI_BITS-1:0] tx_data;
   logic                tx_valid;
   logic                tx_ready;
   logic [SPI_BITS-1:0] rx_data;
   logic                rx_valid;
   logic                underrun;
   logic                busy;

   modport slave (
      input  sclk, cs_n, mosi, tx_data, tx_valid,
      output miso, miso_oe, tx_ready, rx_data, rx_valid, underrun, busy
   );

   modport master (
      output sclk, cs_n, mosi, tx_data, tx_valid,
      input  miso, miso_oe, tx_ready, rx_data, rx_valid, underrun, busy
   );

endinterface

// File: rtl/spi_slave_sync.sv
// N-stage synchronizer with registered rise/fall detect; the reset value
// lets a pin held at its reset level produce no spurious edge.
module spi_slave_sync #(
   parameter int unsigned STAGES  = 2,
   parameter bit          RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic q_o,
   output logic rise_o,
   output logic fall_o
);

   logic [STAGES-1:0] sync_q;
   logic              prev_q;
   logic              rise_q;
   logic              fall_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= {STAGES{RST_VAL}};
         prev_q <= RST_VAL;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d_i};
         prev_q <= sync_q[STAGES-1];
         rise_q <= sync_q[STAGES-1] & ~prev_q;
         fall_q <= ~sync_q[STAGES-1] & prev_q;
      end
   end

   assign q_o    = sync_q[STAGES-1];
   assign rise_o = rise_q;
   assign fall_o = fall_q;

endmodule

// File: rtl/spi_slave.sv
// SPI Mode 0 responder, LSB-first 8-bit frames, with a one-entry TX buffer.
module spi_slave
   import spi_slave_pkg::*;
#(
   parameter int unsigned         SYNC_STAGES = 2,
   parameter logic [SPI_BITS-1:0] DUMMY       = DUMMY_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   spi_slave_if.slave  bus_io
);

   state_e               state_q;
   logic [SPI_BITS-1:0]  shr_q;
   logic [SPI_BITS-1:0]  buf_q;
   logic                 buf_full_q;
   logic [SPI_CNT_W-1:0] cnt_q;
   logic                 mbit_q;
   logic [SPI_BITS-1:0]  rx_data_q;
   logic                 rx_valid_q;
   logic                 underrun_q;

   logic sclk_rise, sclk_fall, sclk_sync_unused;
   logic cs_rise, cs_fall, cs_sync_unused;
   logic mosi_s, mosi_rise_unused, mosi_fall_unused;
   logic tx_hs;
   logic load_byte;

   spi_slave_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
      .clk(clk), .rst(rst), .d_i(bus_io.sclk),
      .q_o(sclk_sync_unused), .rise_o(sclk_rise), .fall_o(sclk_fall)
   );

   // cs_n resets low so a select held through reset is not seen as a fresh fall
   spi_slave_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_cs (
      .clk(clk), .rst(rst), .d_i(bus_io.cs_n),
      .q_o(cs_sync_unused), .rise_o(cs_rise), .fall_o(cs_fall)
   );

   spi_slave_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
      .clk(clk), .rst(rst), .d_i(bus_io.mosi),
      .q_o(mosi_s), .rise_o(mosi_rise_unused), .fall_o(mosi_fall_unused)
   );

   assign tx_hs     = bus_io.tx_valid & ~buf_full_q;
   assign load_byte = ((state_q == IDLE) && cs_fall) ||
                      ((state_q == ACTIVE) && !cs_rise && sclk_fall && (cnt_q == '0));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         shr_q      <= '0;
         buf_q      <= '0;
         buf_full_q <= 1'b0;
         cnt_q      <= '0;
         mbit_q     <= 1'b0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         underrun_q <= 1'b0;
      end else begin
         rx_valid_q <= 1'b0;
         underrun_q <= 1'b0;

         // a load in the handshake cycle sees the old (empty) buffer
         if (tx_hs) begin
            buf_q      <= bus_io.tx_data;
            buf_full_q <= 1'b1;
         end else if (load_byte) begin
            buf_full_q <= 1'b0;
         end

         if (load_byte) begin
            shr_q      <= buf_full_q ? buf_q : DUMMY;
            underrun_q <= ~buf_full_q;
         end

         case (state_q)
            IDLE: begin
               if (cs_fall) begin
                  state_q <= ACTIVE;
                  cnt_q   <= '0;
               end
            end
            ACTIVE: begin
               if (cs_rise) begin
                  state_q <= IDLE;
                  cnt_q   <= '0;
               end else if (sclk_rise) begin
                  mbit_q <= mosi_s;
                  cnt_q  <= cnt_q + SPI_CNT_W'(1);
                  if (cnt_q == SPI_CNT_W'(SPI_BITS - 1)) begin
                     rx_data_q  <= {mosi_s, shr_q[SPI_BITS-1:1]};
                     rx_valid_q <= 1'b1;
                  end
               end else if (sclk_fall && (cnt_q != '0)) begin
                  shr_q <= {mbit_q, shr_q[SPI_BITS-1:1]};
               end
            end
         endcase
      end
   end

   assign bus_io.miso     = shr_q[0];
   assign bus_io.miso_oe  = (state_q == ACTIVE);
   assign bus_io.busy     = (state_q == ACTIVE);
   assign bus_io.tx_ready = ~buf_full_q;
   assign bus_io.rx_data  = rx_data_q;
   assign bus_io.rx_valid = rx_valid_q;
   assign bus_io.underrun = underrun_q;

endmodule
